time_keeper: RTL
================

Name: time_keeper

Overview:
- Time-of-day counter for the alarm-clock design, directly upstream of the display mux.
- Produces the running 12-hour time (HOURS_OUT_time, MINUTES_OUT_time, AM_PM_OUT_time) that the mux selects when alarm display is not requested.
- Includes a user set mode: the mode button steps through hour-set and minute-set, and the inc button advances the selected field.
- Emits a one-cycle minute_pulse, used by the alarm comparator.

Parameters:
- SEC_MAX, 59, terminal value of the internal seconds counter (0..SEC_MAX). Reduce in simulation to accelerate rollover.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- tick_en  input  1  one-cycle pulse once per second; advances time in RUN only.
- mode  input  1  one-cycle pulse (debounced upstream); advances the set FSM.
- inc  input  1  one-cycle pulse; increments the field selected by the FSM.
- HOURS_OUT_time  output  4  current hour, 1..12, registered.
- MINUTES_OUT_time  output  6  current minute, 0..59, registered.
- AM_PM_OUT_time  output  1  0 = AM, 1 = PM, registered.
- set_active  output  1  high in SET_HR or SET_MIN.
- minute_pulse  output  1  one-cycle pulse on minute rollover in RUN.
- blink  output  1  display blink enable (see Optional Feature).

Behaviour:
- Reset has priority over all inputs.
  - Reset state: RUN; HOURS=12, MINUTES=0, AM_PM=0 (12:00 AM).
  - Seconds=0; set_active=0, minute_pulse=0, blink=0.
- FSM states: RUN, SET_HR, SET_MIN.
  - mode pulse steps RUN -> SET_HR -> SET_MIN -> RUN.
  - Without a mode pulse, the FSM holds its state.
- RUN, on tick_en:
  - Seconds increments. At SEC_MAX it wraps to 0 and minutes increments.
  - Minutes 59 wraps to 0 and hours increments.
  - Hours 12 -> 1. Hours 11 -> 12 toggles AM_PM.
  - 11:59:SEC_MAX AM -> 12:00:00 PM; 11:59:SEC_MAX PM -> 12:00:00 AM.
- Latency: outputs reflect a tick_en one cycle after it is sampled.
- minute_pulse:
  - Asserted for exactly the one cycle following a seconds wrap in RUN.
  - Never asserted in set states or by inc.
- SET_HR:
  - tick_en is ignored; seconds frozen.
  - inc advances hour using the same 11 -> 12 AM_PM toggle and 12 -> 1 rule, so 24 inc pulses return to the start value.
- SET_MIN:
  - tick_en is ignored.
  - inc advances minutes; 59 -> 0 with no carry into hours.
- Leaving SET_MIN to RUN clears seconds to 0.
- set_active is registered and follows the state in the same cycle as the state register.
- Simultaneous events:
  - mode and inc in the same cycle: mode takes effect, inc is discarded.
  - tick_en together with mode in RUN: the tick is applied and the FSM moves to SET_HR in the same cycle.
  - tick_en together with inc in RUN: inc is ignored.
- Reset asserted mid-set: returns to RUN and 12:00 AM the next cycle.
- Out-of-range values are unreachable: hours never 0 or >12, minutes never >59.

Optional Feature:
- Macro: TIME_KEEPER_BLINK_EN.
- Defined:
  - An internal blink flop toggles on each tick_en while in SET_HR or SET_MIN.
  - The flop clears to 0 on entering RUN and on reset.
  - blink = flop value in set states, 0 in RUN.
- Undefined: blink is tied to constant 0, no flop is present, and tick_en has no effect in set states.

Test Plan:
- Reset: assert reset 2 cycles -> HOURS=12, MINUTES=0, AM_PM=0, set_active=0, minute_pulse=0.
- Rollover with SEC_MAX=3: preload to 11:59 AM via set mode, return to RUN, then 4 tick_en pulses -> 12:00 PM, minute_pulse high exactly 1 cycle after the 4th tick.
- Hour wrap: from 12:59 PM in RUN, a minute rollover -> 1:00 PM, AM_PM unchanged.
- Set mode:
  - mode -> SET_HR; 13 inc pulses from 12 AM -> 1 PM.
  - mode -> SET_MIN; 61 inc pulses from 0 -> 1 with hours unchanged.
  - mode -> RUN, seconds=0.
  - tick_en pulses during set have no effect on time.
- Collisions:
  - mode+inc same cycle in SET_HR -> state SET_MIN, hour unchanged.
  - Reset during SET_MIN -> RUN, 12:00 AM.
- With TIME_KEEPER_BLINK_EN: in SET_HR, 3 tick_en pulses -> blink 1,0,1; mode back to RUN -> blink 0. Without the macro, blink stays 0 throughout.

Source files
------------

// File: rtl/time_keeper.sv
// 12-hour time-of-day counter with a RUN / SET_HR / SET_MIN set mode and a minute pulse.
// Optional display blink enable is built when TIME_KEEPER_BLINK_EN is defined.
module time_keeper #(
    parameter int SEC_MAX = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_en,
    input  logic       mode,
    input  logic       inc,
    output logic [3:0] HOURS_OUT_time,
    output logic [5:0] MINUTES_OUT_time,
    output logic       AM_PM_OUT_time,
    output logic       set_active,
    output logic       minute_pulse,
    output logic       blink
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } state_t;

    localparam int SEC_W = (SEC_MAX < 2) ? 1 : $clog2(SEC_MAX + 1);
    localparam logic [SEC_W-1:0] SEC_TOP = SEC_W'(SEC_MAX);

    state_t           state_q, state_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [3:0]       hr_q, hr_d;
    logic [5:0]       min_q, min_d;
    logic             pm_q, pm_d;
    logic             set_active_q, set_active_d;
    logic             minute_pulse_q, minute_pulse_d;

    function automatic logic [3:0] next_hour(input logic [3:0] h);
        return (h == 4'd12) ? 4'd1 : h + 4'd1;
    endfunction

    // Crossing 11 -> 12 is where the AM/PM half of the day changes.
    function automatic logic hour_flips_half(input logic [3:0] h);
        return (h == 4'd11);
    endfunction

    function automatic logic [5:0] next_minute(input logic [5:0] m);
        return (m == 6'd59) ? 6'd0 : m + 6'd1;
    endfunction

    always_comb begin
        state_d        = state_q;
        sec_d          = sec_q;
        hr_d           = hr_q;
        min_d          = min_q;
        pm_d           = pm_q;
        minute_pulse_d = 1'b0;

        case (state_q)
            RUN: begin
                // inc has no meaning while running; a tick still lands alongside mode.
                if (tick_en) begin
                    if (sec_q == SEC_TOP) begin
                        sec_d          = '0;
                        minute_pulse_d = 1'b1;
                        min_d          = next_minute(min_q);
                        if (min_q == 6'd59) begin
                            hr_d = next_hour(hr_q);
                            if (hour_flips_half(hr_q)) begin
                                pm_d = ~pm_q;
                            end
                        end
                    end else begin
                        sec_d = sec_q + SEC_W'(1);
                    end
                end
                if (mode) begin
                    state_d = SET_HR;
                end
            end
            SET_HR: begin
                if (mode) begin
                    state_d = SET_MIN;
                end else if (inc) begin
                    hr_d = next_hour(hr_q);
                    if (hour_flips_half(hr_q)) begin
                        pm_d = ~pm_q;
                    end
                end
            end
            SET_MIN: begin
                if (mode) begin
                    state_d = RUN;
                    sec_d   = '0;
                end else if (inc) begin
                    min_d = next_minute(min_q);
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        set_active_d = (state_d != RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            sec_q          <= '0;
            hr_q           <= 4'd12;
            min_q          <= 6'd0;
            pm_q           <= 1'b0;
            set_active_q   <= 1'b0;
            minute_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sec_q          <= sec_d;
            hr_q           <= hr_d;
            min_q          <= min_d;
            pm_q           <= pm_d;
            set_active_q   <= set_active_d;
            minute_pulse_q <= minute_pulse_d;
        end
    end

    assign HOURS_OUT_time   = hr_q;
    assign MINUTES_OUT_time = min_q;
    assign AM_PM_OUT_time   = pm_q;
    assign set_active       = set_active_q;
    assign minute_pulse     = minute_pulse_q;

`ifdef TIME_KEEPER_BLINK_EN
    logic blink_q, blink_d;

    // Toggles on each second while setting; forced low whenever the next state is RUN.
    always_comb begin
        blink_d = blink_q;
        if (state_d == RUN) begin
            blink_d = 1'b0;
        end else if ((state_q != RUN) && tick_en) begin
            blink_d = ~blink_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_q <= 1'b0;
        end else begin
            blink_q <= blink_d;
        end
    end

    assign blink = blink_q & set_active_q;
`else
    assign blink = 1'b0;
`endif

endmodule
